// File: rtl/event_ingress_queue_pkg.sv
// Shared types and constants for the monitor event ingress queue.
// Event layout and drop counter sizing live here.
package event_ingress_pkg;

  localparam int DATA_W    = 32;
  localparam int TS_W      = 48;
  localparam int N_STREAMS = 3;
  localparam int DROP_W    = 16;

  typedef struct packed {
    logic [N_STREAMS-1:0][DATA_W-1:0] x;
    logic [N_STREAMS-1:0]             has;
    logic [TS_W-1:0]                  ts;
  } event_t;

  function automatic logic any_has(
    input logic [N_STREAMS-1:0] h
  );
    return |h;
  endfunction

endpackage

// File: rtl/event_ingress_queue_if.sv
// Producer-side and monitor-side bundle of the event ingress queue.
// master = event producer / observer, slave = the queue.
interface event_ingress_queue_if
  import event_ingress_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int TS_W   = 48,
  parameter int LVL_W  = 4
);

  logic                     in_valid;
  logic                     in_ready;
  logic signed [DATA_W-1:0] in_x1;
  logic signed [DATA_W-1:0] in_x2;
  logic signed [DATA_W-1:0] in_x3;
  logic                     in_has1;
  logic                     in_has2;
  logic                     in_has3;

  logic signed [DATA_W-1:0] out_x1;
  logic signed [DATA_W-1:0] out_x2;
  logic signed [DATA_W-1:0] out_x3;
  logic                     out_has1;
  logic                     out_has2;
  logic                     out_has3;
  logic [TS_W-1:0]          out_ts;
  logic [LVL_W-1:0]         level;
  logic [DROP_W-1:0]        drop_cnt;

  modport master (
    output in_valid,
    output in_x1,
    output in_x2,
    output in_x3,
    output in_has1,
    output in_has2,
    output in_has3,
    input  in_ready,
    input  out_x1,
    input  out_x2,
    input  out_x3,
    input  out_has1,
    input  out_has2,
    input  out_has3,
    input  out_ts,
    input  level,
    input  drop_cnt
  );

  modport slave (
    input  in_valid,
    input  in_x1,
    input  in_x2,
    input  in_x3,
    input  in_has1,
    input  in_has2,
    input  in_has3,
    output in_ready,
    output out_x1,
    output out_x2,
    output out_x3,
    output out_has1,
    output out_has2,
    output out_has3,
    output out_ts,
    output level,
    output drop_cnt
  );

endinterface

// File: rtl/event_ingress_queue_sync_fifo.sv
// Generic single-clock FIFO with occupancy count.
// Head entry is read combinationally; full/empty come from the level.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [LW-1:0]    r_lvl;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_lvl == LW'(DEPTH));
  assign o_empty = (r_lvl == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_data  = r_mem[r_rp];
  assign o_level = r_lvl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_lvl <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      unique case ({w_push, w_pop})
        2'b10:   r_lvl <= r_lvl + LW'(1);
        2'b01:   r_lvl <= r_lvl - LW'(1);
        default: r_lvl <= r_lvl;
      endcase
    end
  end

  // Storage is not reset; the pointers/level define what is valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end

endmodule

// File: rtl/event_ingress_queue.sv
// Timestamps bursty input events and replays them to the monitor
// as one-cycle has pulses separated by a fixed idle gap.
module event_ingress_queue
  import event_ingress_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 48,
  parameter int GAP    = 4
) (
  input logic                 clk,
  input logic                 rst,
  input logic                 en,
  event_ingress_queue_if.slave bus
);

  localparam int LW = $clog2(DEPTH) + 1;
  localparam int GW = $clog2(GAP + 1);
  localparam int EW = N_STREAMS * DATA_W + N_STREAMS + TS_W;

  logic [TS_W-1:0]      r_ts_cnt;
  logic [GW-1:0]        r_gap;
  logic [DROP_W-1:0]    r_drop;
  logic [DATA_W-1:0]    r_x1;
  logic [DATA_W-1:0]    r_x2;
  logic [DATA_W-1:0]    r_x3;
  logic [N_STREAMS-1:0] r_has;
  logic [TS_W-1:0]      r_ots;

  logic [N_STREAMS-1:0] w_in_has;
  logic                 w_any;
  logic [EW-1:0]        w_wr;
  logic [EW-1:0]        w_rd;
  logic [DATA_W-1:0]    w_rd_x1;
  logic [DATA_W-1:0]    w_rd_x2;
  logic [DATA_W-1:0]    w_rd_x3;
  logic [N_STREAMS-1:0] w_rd_has;
  logic [TS_W-1:0]      w_rd_ts;
  logic [LW-1:0]        w_level;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_drop;

  assign w_in_has = {bus.in_has3, bus.in_has2, bus.in_has1};
  assign w_any    = any_has(w_in_has);
  assign w_wr     = {bus.in_x3, bus.in_x2, bus.in_x1,
                     w_in_has, r_ts_cnt};
  assign {w_rd_x3, w_rd_x2, w_rd_x1, w_rd_has, w_rd_ts} = w_rd;

  // Ready follows the registered level, so a same-cycle pop never
  // lets a full queue accept.
  assign bus.in_ready = rst & ~w_full;

  assign w_push = bus.in_valid & bus.in_ready & w_any;
  assign w_drop = bus.in_valid & w_any & w_full;
  assign w_pop  = en & ~w_empty & (r_gap == '0);

  sync_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_wr),
    .o_data  (w_rd),
    .o_level (w_level),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ts_cnt <= '0;
      r_gap    <= '0;
      r_drop   <= '0;
      r_x1     <= '0;
      r_x2     <= '0;
      r_x3     <= '0;
      r_has    <= '0;
      r_ots    <= '0;
    end else begin
      if (en) r_ts_cnt <= r_ts_cnt + TS_W'(1);
      if (w_drop && r_drop != '1) r_drop <= r_drop + DROP_W'(1);
      if (w_pop) begin
        r_gap <= GW'(GAP);
        r_x1  <= w_rd_x1;
        r_x2  <= w_rd_x2;
        r_x3  <= w_rd_x3;
        r_has <= w_rd_has;
        r_ots <= w_rd_ts;
      end else begin
        r_has <= '0;
        if (en && r_gap != '0) r_gap <= r_gap - GW'(1);
      end
    end
  end

  assign bus.out_x1   = r_x1;
  assign bus.out_x2   = r_x2;
  assign bus.out_x3   = r_x3;
  assign bus.out_has1 = r_has[0];
  assign bus.out_has2 = r_has[1];
  assign bus.out_has3 = r_has[2];
  assign bus.out_ts   = r_ots;
  assign bus.level    = w_level;
  assign bus.drop_cnt = r_drop;

endmodule

// File: tb/tb_event_ingress_queue.sv
// Directed bench for the event ingress queue with a pulse scoreboard.
// Pushed events are queued as expectations and popped per out_has pulse.
module tb_event_ingress_queue;
  import event_ingress_pkg::*;

  localparam int DEPTH = 8;
  localparam int GAP   = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic en  = 1'b0;

  always #5 clk = ~clk;

  event_ingress_queue_if #(
    .DATA_W (DATA_W),
    .TS_W   (TS_W),
    .LVL_W  (LW)
  ) bus ();

  event_ingress_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TS_W   (TS_W),
    .GAP    (GAP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_pulse = -100;
  int m_lvl   = 0;
  int m_drop  = 0;
  logic [TS_W-1:0] m_ts = '0;
  event_t sb[$];
  int pulses[$];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    event_t e;
    logic [2:0] h;
    @(posedge clk);
    h = {bus.in_has3, bus.in_has2, bus.in_has1};
    if (!rst) begin
      sb.delete();
      m_lvl = 0;
      m_drop = 0;
      m_ts = '0;
      last_pulse = -100;
    end else begin
      if (bus.in_valid && h != 3'b000) begin
        if (m_lvl < DEPTH) begin
          e.x[0] = bus.in_x1;
          e.x[1] = bus.in_x2;
          e.x[2] = bus.in_x3;
          e.has  = h;
          e.ts   = m_ts;
          sb.push_back(e);
          m_lvl++;
        end else if (m_drop < 16'hFFFF) begin
          m_drop++;
        end
      end
      if (en) m_ts = m_ts + 1'b1;
    end
    @(negedge clk);
    cyc++;
    h = {bus.out_has3, bus.out_has2, bus.out_has1};
    if (h != 3'b000) begin
      pulses.push_back(cyc);
      check("pulse_spacing", 64'(cyc - last_pulse >= GAP + 1), 64'(1));
      last_pulse = cyc;
      if (sb.size() == 0) begin
        check("spurious_pulse", 64'(h), 64'(0));
      end else begin
        e = sb.pop_front();
        m_lvl--;
        check("ev_x1", 64'(unsigned'(bus.out_x1)), 64'(e.x[0]));
        check("ev_x2", 64'(unsigned'(bus.out_x2)), 64'(e.x[1]));
        check("ev_x3", 64'(unsigned'(bus.out_x3)), 64'(e.x[2]));
        check("ev_has", 64'(h), 64'(e.has));
        check("ev_ts", 64'(bus.out_ts), 64'(e.ts));
      end
    end
  endtask

  task automatic drive(input int x1, input int x2, input int x3,
                       input logic [2:0] h);
    bus.in_valid = 1'b1;
    bus.in_x1    = x1;
    bus.in_x2    = x2;
    bus.in_x3    = x3;
    bus.in_has1  = h[0];
    bus.in_has2  = h[1];
    bus.in_has3  = h[2];
    step();
    bus.in_valid = 1'b0;
    bus.in_has1  = 1'b0;
    bus.in_has2  = 1'b0;
    bus.in_has3  = 1'b0;
  endtask

  initial begin
    int c0;
    bus.in_valid = 1'b0;
    bus.in_x1 = '0;
    bus.in_x2 = '0;
    bus.in_x3 = '0;
    bus.in_has1 = 1'b0;
    bus.in_has2 = 1'b0;
    bus.in_has3 = 1'b0;
    rst = 1'b0;
    en  = 1'b1;

    // reset
    repeat (5) begin
      step();
      check("rst_in_ready", 64'(bus.in_ready), 64'(0));
    end
    check("rst_has", 64'({bus.out_has3, bus.out_has2, bus.out_has1}), 64'(0));
    check("rst_x1", 64'(unsigned'(bus.out_x1)), 64'(0));
    check("rst_ts", 64'(bus.out_ts), 64'(0));
    check("rst_level", 64'(bus.level), 64'(0));
    check("rst_drop", 64'(bus.drop_cnt), 64'(0));
    rst = 1'b1;
    step();
    check("ready_after_rst", 64'(bus.in_ready), 64'(1));

    // single event
    pulses.delete();
    c0 = cyc;
    drive(1, 2, 0, 3'b011);
    step();
    check("single_cnt", 64'(pulses.size()), 64'(1));
    check("single_at", 64'(pulses[0]), 64'(c0 + 2));
    check("single_has", 64'({bus.out_has3, bus.out_has2, bus.out_has1}), 64'(3'b011));
    check("single_ts", 64'(bus.out_ts), 64'(1));
    step();
    check("single_clear", 64'({bus.out_has3, bus.out_has2, bus.out_has1}), 64'(0));
    check("single_hold_x2", 64'(unsigned'(bus.out_x2)), 64'(2));
    check("single_level", 64'(bus.level), 64'(0));

    // burst of three, GAP+1 spacing
    repeat (6) step();
    pulses.delete();
    c0 = cyc;
    for (int i = 0; i < 3; i++) drive(4 + i, 5, 1, 3'b111);
    repeat (2) step();
    check("burst_hold_x1", 64'(unsigned'(bus.out_x1)), 64'(4));
    check("burst_gap_has", 64'({bus.out_has3, bus.out_has2, bus.out_has1}), 64'(0));
    repeat (10) step();
    check("burst_cnt", 64'(pulses.size()), 64'(3));
    check("burst_p0", 64'(pulses[0]), 64'(c0 + 2));
    check("burst_p1", 64'(pulses[1]), 64'(c0 + 7));
    check("burst_p2", 64'(pulses[2]), 64'(c0 + 12));
    check("burst_level", 64'(bus.level), 64'(0));

    // overflow with emission frozen
    pulses.delete();
    en = 1'b0;
    for (int i = 0; i < 10; i++) drive(100 + i, 200 + i, i, 3'b101);
    check("ovf_level", 64'(bus.level), 64'(8));
    check("ovf_ready", 64'(bus.in_ready), 64'(0));
    check("ovf_drop", 64'(bus.drop_cnt), 64'(2));
    check("ovf_frozen", 64'(pulses.size()), 64'(0));
    en = 1'b1;
    repeat (60) step();
    check("ovf_emitted", 64'(pulses.size()), 64'(8));
    check("ovf_sb_empty", 64'(sb.size()), 64'(0));
    check("ovf_level_end", 64'(bus.level), 64'(0));

    // all-flags-zero event is filtered
    drive(7, 7, 7, 3'b000);
    repeat (8) step();
    check("filt_level", 64'(bus.level), 64'(0));
    check("filt_drop", 64'(bus.drop_cnt), 64'(2));
    check("filt_nopulse", 64'(pulses.size()), 64'(8));

    // reset with events pending
    en = 1'b0;
    for (int i = 0; i < 5; i++) drive(50 + i, 0, 0, 3'b001);
    check("mid_level_pre", 64'(bus.level), 64'(5));
    rst = 1'b0;
    step();
    check("mid_ready", 64'(bus.in_ready), 64'(0));
    check("mid_level", 64'(bus.level), 64'(0));
    check("mid_drop", 64'(bus.drop_cnt), 64'(0));
    check("mid_ts", 64'(bus.out_ts), 64'(0));
    rst = 1'b1;
    en = 1'b1;
    pulses.delete();
    repeat (20) step();
    check("mid_nopulse", 64'(pulses.size()), 64'(0));
    drive(9, 0, 0, 3'b001);
    repeat (3) step();
    check("mid_new_cnt", 64'(pulses.size()), 64'(1));
    check("ts_restart", 64'(bus.out_ts), 64'(20));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
